// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - state, mux-select and ALU opcode encodings for the ARM control unit
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH0  = 4'd1,
        S_FETCH1  = 4'd2,
        S_FETCH2  = 4'd3,
        S_DECODE  = 4'd4,
        S_DP_EXEC = 4'd5,
        S_LS_ADDR = 4'd6,
        S_LS_DATA = 4'd7,
        S_LS_WAIT = 4'd8,
        S_LD_WB   = 4'd9,
        S_BR_LINK = 4'd10,
        S_BR_EXEC = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    // Register-file write address select
    localparam logic [1:0] WRA_RD  = 2'd0;
    localparam logic [1:0] WRA_RN  = 2'd1;
    localparam logic [1:0] WRA_R15 = 2'd2;
    localparam logic [1:0] WRA_R14 = 2'd3;

    // Register-file read port (SRA/SRB) select
    localparam logic [1:0] RS_RN  = 2'd0;
    localparam logic [1:0] RS_RM  = 2'd1;
    localparam logic [1:0] RS_RD  = 2'd2;
    localparam logic [1:0] RS_R15 = 2'd3;

    localparam logic [1:0] SALUB_RF     = 2'd0;
    localparam logic [1:0] SALUB_CONST4 = 2'd1;
    localparam logic [1:0] SALUB_IMM    = 2'd2;
    localparam logic [1:0] SALUB_MDR    = 2'd3;

    localparam logic [1:0] SISE_IMM8ROT = 2'd0;
    localparam logic [1:0] SISE_IMM12   = 2'd1;
    localparam logic [1:0] SISE_IMM24X4 = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // TST/TEQ/CMP/CMN only update flags
    function automatic logic is_test_op(input logic [3:0] opcode);
        return opcode[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/control_unit_cond_eval.sv
// rtl/control_unit_cond_eval.sv - ARM condition-code evaluation against {N,Z,C,V}
module cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'ha: pass = (n == v);
            4'hb: pass = (n != v);
            4'hc: pass = !z && (n == v);
            4'hd: pass = z || (n != v);
            4'he: pass = 1'b1;
            default: pass = 1'b0;   // NV: never executes
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle ARM control FSM with memory-wait watchdog
module control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [31:0]   IR_Out,
    input  logic [3:0]    SR_Flags,
    input  logic          MFC,
    output logic          MFA,
    output logic          RW_RAM,
    output logic [1:0]    DataSize,
    output logic          RF_CLR,
    output logic          RF_RW,
    output logic [1:0]    WRA,
    output logic [1:0]    SRA,
    output logic [1:0]    SRB,
    output logic [1:0]    SALU,
    output logic [1:0]    SISE,
    output logic [1:0]    SALUB,
    output logic [3:0]    ALUA,
    output logic          SSAB,
    output logic          SSOP,
    output logic          SMA,
    output logic          ISO,
    output logic          MAR_EN,
    output logic          SR_EN,
    output logic          SE2_EN,
    output logic          MDR_EN,
    output logic          SHIFTER_EN,
    output logic          IR_EN,
    output logic          SE1_EN,
    output logic          SR_CLR,
    output logic          MAR_CLR,
    output logic          MDR_CLR,
    output logic          IR_CLR,
    output logic          FAULT,
    output logic [CW-1:0] STATE
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             cond_pass;
    logic             unused_ir;

    assign unused_ir = ^IR_Out[19:0];

    cond_eval u_cond_eval (
        .cond  (IR_Out[31:28]),
        .flags (SR_Flags),
        .pass  (cond_pass)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    assign STATE = CW'(state);

    always_comb begin
        next_state    = state;
        wait_cnt_next = '0;
        MFA = 1'b0; RW_RAM = 1'b0; DataSize = 2'b00;
        RF_CLR = 1'b0; RF_RW = 1'b0;
        WRA = WRA_RD; SRA = RS_RN; SRB = RS_RN; SALU = 2'b00;
        SISE = SISE_IMM8ROT; SALUB = SALUB_RF; ALUA = 4'b0000;
        SSAB = 1'b0; SSOP = 1'b0; SMA = 1'b0; ISO = 1'b0;
        MAR_EN = 1'b0; SR_EN = 1'b0; SE2_EN = 1'b0; MDR_EN = 1'b0;
        SHIFTER_EN = 1'b0; IR_EN = 1'b0; SE1_EN = 1'b0;
        SR_CLR = 1'b0; MAR_CLR = 1'b0; MDR_CLR = 1'b0; IR_CLR = 1'b0;
        FAULT = 1'b0;

        case (state)
            S_RST: begin
                RF_CLR = 1'b1; SR_CLR = 1'b1; MAR_CLR = 1'b1;
                MDR_CLR = 1'b1; IR_CLR = 1'b1;
                next_state = S_FETCH0;
            end
            S_FETCH0: begin
                SRB = RS_R15; SALUB = SALUB_RF; ALUA = ALU_MOV; MAR_EN = 1'b1;
                next_state = S_FETCH1;
            end
            S_FETCH1: begin
                MFA = 1'b1; RW_RAM = 1'b1; DataSize = 2'b10; MDR_EN = 1'b1;
                SRA = RS_R15; SALUB = SALUB_CONST4; ALUA = ALU_ADD;
                WRA = WRA_R15; RF_RW = 1'b1;
                next_state = S_FETCH2;
            end
            S_FETCH2: begin
                // IR reloads every wait cycle; its final load lands on the MFC edge
                MFA = 1'b1; RW_RAM = 1'b1; MDR_EN = 1'b1; IR_EN = 1'b1;
                if (MFC)                           next_state = S_DECODE;
                else if (wait_cnt == CNT_W'(WAIT_MAX)) next_state = S_FAULT;
                else                               wait_cnt_next = wait_cnt + CNT_W'(1);
            end
            S_DECODE: begin
                if (!cond_pass) next_state = S_FETCH0;
                else begin
                    case (IR_Out[27:25])
                        3'b000, 3'b001: next_state = S_DP_EXEC;
                        3'b010, 3'b011: next_state = S_LS_ADDR;
                        3'b101:         next_state = IR_Out[24] ? S_BR_LINK : S_BR_EXEC;
                        default:        next_state = S_FETCH0;
                    endcase
                end
            end
            S_DP_EXEC: begin
                SRA = RS_RN; SRB = RS_RM; SALU = 2'b01; SHIFTER_EN = 1'b1;
                SSAB = IR_Out[25];
                SALUB = IR_Out[25] ? SALUB_IMM : SALUB_RF;
                SR_EN = IR_Out[20]; WRA = WRA_RD;
                RF_RW = !is_test_op(IR_Out[24:21]);
                next_state = S_FETCH0;
            end
            S_LS_ADDR: begin
                SRA = RS_RN;
                ALUA = IR_Out[23] ? ALU_ADD : ALU_SUB;
                SALUB = IR_Out[25] ? SALUB_RF : SALUB_IMM;
                SISE = SISE_IMM12; MAR_EN = 1'b1;
                next_state = IR_Out[20] ? S_LS_WAIT : S_LS_DATA;
            end
            S_LS_DATA: begin
                SRB = RS_RD; SALUB = SALUB_RF; ALUA = ALU_MOV; MDR_EN = 1'b1;
                next_state = S_LS_WAIT;
            end
            S_LS_WAIT: begin
                MFA = 1'b1; RW_RAM = IR_Out[20];
                DataSize = IR_Out[22] ? 2'b00 : 2'b10;
                MDR_EN = IR_Out[20];
                if (MFC)                           next_state = IR_Out[20] ? S_LD_WB : S_FETCH0;
                else if (wait_cnt == CNT_W'(WAIT_MAX)) next_state = S_FAULT;
                else                               wait_cnt_next = wait_cnt + CNT_W'(1);
            end
            S_LD_WB: begin
                ISO = 1'b1; WRA = WRA_RD; RF_RW = 1'b1;
                next_state = S_FETCH0;
            end
            S_BR_LINK: begin
                SRB = RS_R15; SALUB = SALUB_RF; ALUA = ALU_MOV;
                WRA = WRA_R14; RF_RW = 1'b1;
                next_state = S_BR_EXEC;
            end
            S_BR_EXEC: begin
                SRA = RS_R15; SE1_EN = 1'b1; SISE = SISE_IMM24X4;
                SALUB = SALUB_IMM; ALUA = ALU_ADD; WRA = WRA_R15; RF_RW = 1'b1;
                next_state = S_FETCH0;
            end
            S_FAULT: begin
                FAULT = 1'b1;
                next_state = S_FAULT;
            end
            default: next_state = S_RST;
        endcase
    end
endmodule
